// File: rtl/clip_recorder_ctrl.sv
// Record/playback controller for NUM_CLIPS audio clips sharing one single-port
// memory. Runs on the system clock and derives its own sample-rate tick.
module clip_recorder_ctrl #(
    parameter  int SAMPLE_W  = 16,
    parameter  int ADDR_W    = 17,
    parameter  int NUM_CLIPS = 2,
    parameter  int CLK_DIV   = 2500,
    localparam int CLIP_W    = $clog2(NUM_CLIPS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     record,
    input  logic                     play,
    input  logic                     stop,
    input  logic [CLIP_W-1:0]        clip_sel,
    input  logic                     loop,
    input  logic [SAMPLE_W-1:0]      sample_in,
    output logic [SAMPLE_W-1:0]      sample_out,
    output logic                     sample_valid,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [CLIP_W+ADDR_W-1:0] mem_addr,
    output logic [SAMPLE_W-1:0]      mem_din,
    input  logic [SAMPLE_W-1:0]      mem_dout,
    output logic [1:0]               state,
    output logic                     busy,
    output logic [CLIP_W-1:0]        cur_clip,
    output logic [ADDR_W:0]          sel_len
);

    localparam int                CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CLIP_W:0]   NCLIPS  = (CLIP_W + 1)'(NUM_CLIPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t              st_q, st_d;
    logic [CNT_W-1:0]    cnt;
    logic                tick;
    logic [ADDR_W-1:0]   offset, offset_d;
    logic [CLIP_W-1:0]   cur_clip_d;
    logic [ADDR_W:0]     len [NUM_CLIPS];
    logic                len_we;
    logic [CLIP_W-1:0]   len_idx;
    logic [ADDR_W:0]     len_d;
    logic [ADDR_W:0]     cur_len;
    logic                sel_ok;
    logic                rd_issue, rd_pend;

    assign tick    = (cnt == CNT_MAX);
    // clip_sel values beyond NUM_CLIPS (non power-of-two counts) are treated
    // as empty clips and cannot be recorded to.
    assign sel_ok  = ({1'b0, clip_sel} < NCLIPS);
    assign sel_len = sel_ok ? len[clip_sel] : '0;
    assign cur_len = len[cur_clip];
    assign state   = st_q;
    assign busy    = (st_q != S_IDLE);

    // Free-running sample-rate divider, independent of FSM state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)            cnt <= '0;
        else if (tick)         cnt <= '0;
        else                   cnt <= cnt + 1'b1;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) st_q <= S_IDLE;
        else        st_q <= st_d;
    end

    // Next-state, datapath updates and combinational memory port.
    always_comb begin
        st_d       = st_q;
        offset_d   = offset;
        cur_clip_d = cur_clip;
        len_we     = 1'b0;
        len_idx    = cur_clip;
        len_d      = '0;
        rd_issue   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        case (st_q)
            S_IDLE: begin
                if (record && sel_ok) begin
                    cur_clip_d = clip_sel;
                    offset_d   = '0;
                    len_we     = 1'b1;
                    len_idx    = clip_sel;
                    len_d      = '0;
                    st_d       = S_REC;
                end else if (play && sel_len != '0) begin
                    cur_clip_d = clip_sel;
                    offset_d   = '0;
                    st_d       = S_PLAY;
                end
            end
            S_REC: begin
                if (tick) begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = {cur_clip, offset};
                    mem_din  = sample_in;
                    offset_d = offset + 1'b1;
                    // Clip full: stop rather than wrap into our own start.
                    if (offset == '1) begin
                        len_we = 1'b1;
                        len_d  = DEPTH;
                        st_d   = S_IDLE;
                    end else if (stop) begin
                        len_we = 1'b1;
                        len_d  = {1'b0, offset} + 1'b1;
                        st_d   = S_IDLE;
                    end
                end else if (stop) begin
                    len_we = 1'b1;
                    len_d  = {1'b0, offset};
                    st_d   = S_IDLE;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    mem_en   = 1'b1;
                    mem_addr = {cur_clip, offset};
                    rd_issue = 1'b1;
                    if ({1'b0, offset} + 1'b1 == cur_len) begin
                        if (loop) offset_d = '0;
                        else      st_d     = S_IDLE;
                    end else begin
                        offset_d = offset + 1'b1;
                    end
                end
                if (stop) st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    // Offset, active clip and per-clip length registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            offset   <= '0;
            cur_clip <= '0;
            for (int i = 0; i < NUM_CLIPS; i++) len[i] <= '0;
        end else begin
            offset   <= offset_d;
            cur_clip <= cur_clip_d;
            if (len_we) len[len_idx] <= len_d;
        end
    end

    // Read return path: capture mem_dout the cycle after the read, pulse valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_pend      <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            rd_pend      <= rd_issue;
            sample_valid <= rd_pend;
            if (rd_pend) sample_out <= mem_dout;
        end
    end

endmodule

// File: tb/tb_clip_recorder_ctrl.sv
// Directed bench for clip_recorder_ctrl with CLK_DIV=4, ADDR_W=3, NUM_CLIPS=2.
module tb_clip_recorder_ctrl;

    logic        clock, reset;
    logic        record, play, stop, loop;
    logic        clip_sel;
    logic [15:0] sample_in, sample_out, mem_din, mem_dout;
    logic        sample_valid, mem_en, mem_we, busy;
    logic [3:0]  mem_addr, sel_len;
    logic [1:0]  state;
    logic        cur_clip;

    clip_recorder_ctrl #(.SAMPLE_W(16), .ADDR_W(3), .NUM_CLIPS(2), .CLK_DIV(4)) dut (
        .clock(clock), .reset(reset), .record(record), .play(play), .stop(stop),
        .clip_sel(clip_sel), .loop(loop), .sample_in(sample_in),
        .sample_out(sample_out), .sample_valid(sample_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .state(state), .busy(busy), .cur_clip(cur_clip),
        .sel_len(sel_len)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port clip memory.
    logic [15:0] mem [0:15];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else        mem_dout      <= mem[mem_addr];
        end
    end

    int cyc;
    always @(posedge clock) cyc <= cyc + 1;

    int tests, fails;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Read/valid monitor: logs read addresses and returned samples, checks latency.
    logic        mon_on;
    logic [3:0]  ra[$];
    int          rt[$];
    logic [15:0] vd[$];
    always @(negedge clock) begin
        #2;
        if (mon_on && reset) begin
            if (mem_en && !mem_we) begin
                ra.push_back(mem_addr);
                rt.push_back(cyc);
            end
            if (sample_valid) begin
                vd.push_back(sample_out);
                if (rt.size() > 0) chk("valid_latency", cyc - rt.pop_front(), 2);
                else begin
                    tests++; fails++;
                    $display("FAIL valid_without_read: got sample_valid=1 expected no pulse");
                end
            end
        end
    end

    typedef struct {
        logic rec, ply, stp, clip, lp;
        logic [15:0] din;
        logic [1:0]  st;
        logic        en, we;
        logic [3:0]  addr;
        logic [15:0] mdin;
        logic [3:0]  slen;
        logic        vld;
        logic [15:0] sout;
    } vec_t;

    function automatic vec_t mk(input logic r, p, s, c, l, input logic [15:0] di,
                                input logic [1:0] st, input logic en, we,
                                input logic [3:0] a, input logic [15:0] md,
                                input logic [3:0] sl, input logic v, input logic [15:0] so);
        vec_t t;
        t.rec = r; t.ply = p; t.stp = s; t.clip = c; t.lp = l; t.din = di;
        t.st = st; t.en = en; t.we = we; t.addr = a; t.mdin = md;
        t.slen = sl; t.vld = v; t.sout = so;
        return t;
    endfunction

    task automatic idle_inputs();
        record = 0; play = 0; stop = 0; loop = 0; clip_sel = 0; sample_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        repeat (2) @(negedge clock);
        reset = 1;
    endtask

    vec_t tv[23];
    int n, last, extra, na, nv;
    logic found;

    initial begin
        tests = 0; fails = 0; mon_on = 0;
        reset = 0;
        idle_inputs();
        // Cycle-by-cycle table from reset; ticks fall in steps 3,7,11,15,19.
        //          rec ply stp clp lp din     st en we ad mdin   sl v sout
        tv[0]  = mk(0, 0, 0, 0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  0, 0, 16'h0);
        tv[1]  = mk(0, 1, 0, 1, 0, 16'h0,  0, 0, 0, 0, 16'h0,  0, 0, 16'h0);
        tv[2]  = mk(0, 0, 0, 0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  0, 0, 16'h0);
        tv[3]  = mk(0, 0, 0, 0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  0, 0, 16'h0);
        tv[4]  = mk(1, 1, 0, 0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  0, 0, 16'h0);
        tv[5]  = mk(0, 1, 0, 0, 0, 16'h0,  1, 0, 0, 0, 16'h0,  0, 0, 16'h0);
        tv[6]  = mk(1, 0, 0, 0, 0, 16'h0,  1, 0, 0, 0, 16'h0,  0, 0, 16'h0);
        tv[7]  = mk(0, 0, 0, 0, 0, 16'h11, 1, 1, 1, 0, 16'h11, 0, 0, 16'h0);
        tv[8]  = mk(0, 0, 0, 0, 0, 16'h0,  1, 0, 0, 0, 16'h0,  0, 0, 16'h0);
        tv[9]  = mk(0, 0, 0, 0, 0, 16'h0,  1, 0, 0, 0, 16'h0,  0, 0, 16'h0);
        tv[10] = mk(0, 0, 0, 0, 0, 16'h0,  1, 0, 0, 0, 16'h0,  0, 0, 16'h0);
        tv[11] = mk(0, 0, 1, 0, 0, 16'h22, 1, 1, 1, 1, 16'h22, 0, 0, 16'h0);
        tv[12] = mk(0, 0, 0, 0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  2, 0, 16'h0);
        tv[13] = mk(0, 1, 0, 0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  2, 0, 16'h0);
        tv[14] = mk(0, 0, 0, 0, 0, 16'h0,  2, 0, 0, 0, 16'h0,  2, 0, 16'h0);
        tv[15] = mk(0, 0, 0, 0, 0, 16'h0,  2, 1, 0, 0, 16'h0,  2, 0, 16'h0);
        tv[16] = mk(0, 0, 0, 0, 0, 16'h0,  2, 0, 0, 0, 16'h0,  2, 0, 16'h0);
        tv[17] = mk(0, 0, 0, 0, 0, 16'h0,  2, 0, 0, 0, 16'h0,  2, 1, 16'h11);
        tv[18] = mk(0, 0, 0, 0, 0, 16'h0,  2, 0, 0, 0, 16'h0,  2, 0, 16'h11);
        tv[19] = mk(0, 0, 0, 0, 0, 16'h0,  2, 1, 0, 1, 16'h0,  2, 0, 16'h11);
        tv[20] = mk(0, 0, 0, 0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  2, 0, 16'h11);
        tv[21] = mk(0, 0, 0, 0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  2, 1, 16'h22);
        tv[22] = mk(0, 0, 0, 0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  2, 0, 16'h22);

        @(negedge clock);
        do_reset();
        for (int i = 0; i < 23; i++) begin
            record = tv[i].rec; play = tv[i].ply; stop = tv[i].stp;
            clip_sel = tv[i].clip; loop = tv[i].lp; sample_in = tv[i].din;
            #1;
            chk($sformatf("v%0d state", i), state, tv[i].st);
            chk($sformatf("v%0d busy", i), busy, tv[i].st != 2'd0);
            chk($sformatf("v%0d mem_en", i), mem_en, tv[i].en);
            chk($sformatf("v%0d mem_we", i), mem_we, tv[i].we);
            chk($sformatf("v%0d mem_addr", i), mem_addr, tv[i].addr);
            chk($sformatf("v%0d mem_din", i), mem_din, tv[i].mdin);
            chk($sformatf("v%0d sel_len", i), sel_len, tv[i].slen);
            chk($sformatf("v%0d sample_valid", i), sample_valid, tv[i].vld);
            chk($sformatf("v%0d sample_out", i), sample_out, tv[i].sout);
            @(negedge clock);
        end
        idle_inputs();

        // Full record of clip 1 with a ramp: 8 writes to 8..15, 4 clocks apart.
        do_reset();
        clip_sel = 1; record = 1;
        @(negedge clock);
        record = 0;
        n = 0; last = 0;
        for (int k = 0; k < 60 && n < 8; k++) begin
            sample_in = 16'h0100 + 16'(n);
            #1;
            if (mem_en) begin
                chk("full_we", mem_we, 1);
                chk("full_addr", mem_addr, 8 + n);
                chk("full_din", mem_din, 16'h0100 + n);
                if (n > 0) chk("full_gap", cyc - last, 4);
                last = cyc;
                n++;
            end
            @(negedge clock);
        end
        chk("full_count", n, 8);
        #1;
        chk("full_state", state, 0);
        chk("full_sel_len", sel_len, 8);
        chk("full_cur_clip", cur_clip, 1);
        extra = 0;
        repeat (8) begin
            @(negedge clock); #1;
            if (mem_en) extra++;
        end
        chk("full_no_wrap", extra, 0);
        for (int k = 0; k < 8; k++) chk($sformatf("full_mem%0d", k), mem[8 + k], 16'h0100 + k);

        // Partial record of clip 0, stop between ticks after 3 writes.
        do_reset();
        clip_sel = 0; record = 1;
        @(negedge clock);
        record = 0;
        n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            sample_in = 16'h00A1 + 16'(n);
            #1;
            if (mem_en) begin
                chk("part_addr", mem_addr, n);
                chk("part_din", mem_din, 16'h00A1 + n);
                n++;
            end
            @(negedge clock);
        end
        chk("part_writes", n, 3);
        stop = 1;
        @(negedge clock);
        stop = 0;
        #1;
        chk("part_state", state, 0);
        chk("part_sel_len", sel_len, 3);

        // Non-looping playback of the 3-sample clip.
        ra.delete(); rt.delete(); vd.delete();
        @(negedge clock);
        mon_on = 1; loop = 0; play = 1;
        @(negedge clock);
        play = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (state == 2'd0) break;
            @(negedge clock);
        end
        repeat (4) @(negedge clock);
        #3;
        mon_on = 0;
        chk("play_state", state, 0);
        chk("play_reads", ra.size(), 3);
        chk("play_valids", vd.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < ra.size()) chk($sformatf("play_addr%0d", k), ra[k], k);
            if (k < vd.size()) chk($sformatf("play_data%0d", k), vd[k], 16'h00A1 + k);
        end

        // Loop playback, then stop.
        ra.delete(); rt.delete(); vd.delete();
        @(negedge clock);
        mon_on = 1; loop = 1; play = 1; clip_sel = 0;
        @(negedge clock);
        play = 0;
        repeat (30) @(negedge clock);
        stop = 1;
        @(negedge clock);
        stop = 0;
        #3;
        na = ra.size(); nv = vd.size();
        chk("loop_stop_state", state, 0);
        repeat (12) @(negedge clock);
        #3;
        mon_on = 0;
        chk("loop_enough_reads", na >= 6, 1);
        for (int k = 0; k < na; k++) chk($sformatf("loop_addr%0d", k), ra[k], k % 3);
        chk("loop_no_read_after_stop", ra.size(), na);
        chk("loop_trailing_valid", (vd.size() - nv) <= 1, 1);
        loop = 0;

        // Asynchronous reset in the middle of a REC write tick.
        @(negedge clock);
        clip_sel = 1; record = 1;
        @(negedge clock);
        record = 0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (mem_en) begin found = 1; break; end
            @(negedge clock);
        end
        chk("rst_found_write", found, 1);
        #1;
        reset = 0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        @(negedge clock);
        reset = 1;
        clip_sel = 0; #1;
        chk("rst_len0", sel_len, 0);
        clip_sel = 1; #1;
        chk("rst_len1", sel_len, 0);
        chk("rst_cur_clip", cur_clip, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
